// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command master and its buffer.
package wb_cmd_pkg;

   // Register bus width shared by every block in this slice
   localparam int WB_DATA_WIDTH  = 8;
   localparam int WB_ACK_TIMEOUT = 15;

   // Bits needed to count up to a given timeout value
   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

   localparam int WB_CNT_WIDTH = cnt_width(WB_ACK_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_CAPTURE,
      ST_RESP
   } wb_state_e;

   typedef struct packed {
      logic                     we;
      logic [WB_DATA_WIDTH-1:0] adr;
      logic [WB_DATA_WIDTH-1:0] dat;
   } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible whenever the FIFO is non-empty.
module wb_cmd_fifo
   import wb_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  wb_cmd_t push_data,
   input  logic    pop,
   output wb_cmd_t head,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wb_cmd_t         mem_q [DEPTH];
   wb_cmd_t         mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Next-state for storage, pointers and occupancy count
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers with synchronous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone master: buffers register commands, issues one strobe each with an
// ack timeout, and returns a held response per command in FIFO order.
module wb_cmd_master
   import wb_cmd_pkg::*;
#(
   parameter int DATA_WIDTH  = WB_DATA_WIDTH,
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = WB_ACK_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [DATA_WIDTH-1:0] cmd_adr,
   input  logic [DATA_WIDTH-1:0] cmd_dat,
   output logic                  stb_o,
   output logic                  we_o,
   output logic [DATA_WIDTH-1:0] adr_wr_o,
   output logic [DATA_WIDTH-1:0] adr_rd_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   input  logic                  ack_i,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_we,
   output logic [DATA_WIDTH-1:0] rsp_dat,
   output logic                  rsp_err
);

   localparam int CNT_W = cnt_width(ACK_TIMEOUT);

   wb_state_e             state_q, state_d;
   wb_cmd_t               cmd_q, cmd_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rsp_we_q, rsp_we_d;
   logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
   logic                  rsp_err_q, rsp_err_d;

   wb_cmd_t               fifo_in;
   wb_cmd_t               fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;

   assign fifo_in   = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat};
   assign cmd_ready = !fifo_full;

   wb_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cmd_valid),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Bus outputs follow the command register so they hold their last value between strobes
   assign stb_o     = (state_q == ST_STROBE);
   assign we_o      = cmd_q.we;
   assign adr_wr_o  = cmd_q.adr;
   assign adr_rd_o  = cmd_q.adr;
   assign dat_o     = cmd_q.dat;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_we    = rsp_we_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;

   // Sequencer: fetch, strobe until ack or timeout, capture read data, hold response
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cnt_d     = cnt_q;
      rsp_we_d  = rsp_we_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      fifo_pop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               cnt_d    = '0;
               state_d  = ST_STROBE;
            end
         end
         ST_STROBE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (ack_i) begin
               if (cmd_q.we) begin
                  rsp_we_d  = 1'b1;
                  rsp_dat_d = '0;
                  rsp_err_d = 1'b0;
                  state_d   = ST_RESP;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               rsp_we_d  = cmd_q.we;
               rsp_dat_d = '0;
               rsp_err_d = 1'b1;
               state_d   = ST_RESP;
            end
         end
         ST_CAPTURE: begin
            rsp_we_d  = 1'b0;
            rsp_dat_d = dat_i;
            rsp_err_d = 1'b0;
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer, command, counter and response registers with synchronous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         cnt_q     <= '0;
         rsp_we_q  <= 1'b0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cnt_q     <= cnt_d;
         rsp_we_q  <= rsp_we_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small register-slave model.
module tb_wb_cmd_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_we;
   logic [7:0] cmd_adr;
   logic [7:0] cmd_dat;
   logic       stb_o;
   logic       we_o;
   logic [7:0] adr_wr_o;
   logic [7:0] adr_rd_o;
   logic [7:0] dat_o;
   logic [7:0] dat_i = 8'h00;
   logic       ack_i;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_we;
   logic [7:0] rsp_dat;
   logic       rsp_err;

   int checks = 0;
   int errors = 0;

   // Slave behaviour: 0 = always ack, 1 = never ack address 0x10, 2 = ack on 15th strobe cycle
   int ackMode = 0;
   int runCnt = 0;
   logic [7:0] mem [256];

   logic [9:0] rspQ [$];
   logic [7:0] ackAdrQ [$];
   int         runQ [$];

   wb_cmd_master dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .stb_o     (stb_o),
      .we_o      (we_o),
      .adr_wr_o  (adr_wr_o),
      .adr_rd_o  (adr_rd_o),
      .dat_o     (dat_o),
      .dat_i     (dat_i),
      .ack_i     (ack_i),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_dat   (rsp_dat),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // The slave acks combinationally from the strobe, shaped by the current mode
   assign ack_i = stb_o && ((ackMode == 0) ||
                            (ackMode == 1 && adr_rd_o != 8'h10) ||
                            (ackMode == 2 && runCnt == 14));

   // Register slave: writes land on the ack edge, read data appears one cycle after the ack
   always @(posedge clk) begin
      if (stb_o && ack_i) begin
         if (we_o) mem[adr_wr_o] = dat_o;
         else dat_i <= mem[adr_rd_o];
         ackAdrQ.push_back(adr_wr_o);
      end
   end

   // Measure the length of every contiguous strobe burst
   always @(posedge clk) begin
      if (stb_o) runCnt <= runCnt + 1;
      else if (runCnt != 0) begin
         runQ.push_back(runCnt);
         runCnt <= 0;
      end
   end

   // Log every response handshake as {we, err, dat}
   always @(posedge clk) begin
      if (rsp_valid && rsp_ready) rspQ.push_back({rsp_we, rsp_err, rsp_dat});
   end

   // Hard stop in case something escapes the bounded waits
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it, and reports and counts a failure
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one command and wait (bounded) until it is accepted on an edge
   task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [7:0] dat);
      logic ok;
      ok = 1'b0;
      cmd_we = we;
      cmd_adr = adr;
      cmd_dat = dat;
      cmd_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         ok = cmd_ready;
         tick();
      end
      cmd_valid = 1'b0;
      checkOutput("push_accept", 32'(ok), 32'd1);
   endtask

   // Wait (bounded) until n responses have been logged
   task automatic waitResponses(input int n);
      for (int i = 0; i < 200 && rspQ.size() < n; i++) tick();
      checkOutput("rsp_count", 32'(rspQ.size()), 32'(n));
   endtask

   function automatic logic [31:0] rspAt(input int i);
      return (i < rspQ.size()) ? 32'(rspQ[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] runAt(input int i);
      return (i < runQ.size()) ? 32'(runQ[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] adrAt(input int i);
      return (i < ackAdrQ.size()) ? 32'(ackAdrQ[i]) : 32'hFFFF_FFFF;
   endfunction

   task automatic clearLogs();
      rspQ.delete();
      runQ.delete();
      ackAdrQ.delete();
   endtask

   // Directed sequence of scenarios
   initial begin
      int   n;
      int   firstLow;
      logic acc;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_we = 1'b0;
      cmd_adr = 8'h00;
      cmd_dat = 8'h00;
      rsp_ready = 1'b1;
      repeat (2) tick();

      $display("[TB] reset values");
      checkOutput("rst_stb", 32'(stb_o), 32'd0);
      checkOutput("rst_we", 32'(we_o), 32'd0);
      checkOutput("rst_adr_wr", 32'(adr_wr_o), 32'd0);
      checkOutput("rst_adr_rd", 32'(adr_rd_o), 32'd0);
      checkOutput("rst_dat_o", 32'(dat_o), 32'd0);
      checkOutput("rst_rsp", 32'({rsp_valid, rsp_we, rsp_err, rsp_dat}), 32'd0);
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;
      tick();
      clearLogs();

      $display("[TB] write then read back");
      applyStimulus(1'b1, 8'h05, 8'hA5);
      checkOutput("wr_t1", 32'({stb_o, rsp_valid}), 32'd0);
      tick();
      checkOutput("wr_t2_bus", 32'({stb_o, we_o, adr_wr_o, dat_o}), 32'({1'b1, 1'b1, 8'h05, 8'hA5}));
      tick();
      checkOutput("wr_t3_stb", 32'(stb_o), 32'd0);
      checkOutput("wr_t3_rsp", 32'({rsp_valid, rsp_we, rsp_err, rsp_dat}), 32'({1'b1, 1'b1, 1'b0, 8'h00}));
      tick();
      checkOutput("wr_t4_done", 32'(rsp_valid), 32'd0);
      applyStimulus(1'b0, 8'h05, 8'h00);
      checkOutput("rd_t1", 32'({stb_o, rsp_valid}), 32'd0);
      tick();
      checkOutput("rd_t2_bus", 32'({stb_o, we_o, adr_rd_o}), 32'({1'b1, 1'b0, 8'h05}));
      tick();
      checkOutput("rd_t3", 32'({stb_o, rsp_valid}), 32'd0);
      tick();
      checkOutput("rd_t4_rsp", 32'({rsp_valid, rsp_we, rsp_err, rsp_dat}), 32'({1'b1, 1'b0, 1'b0, 8'hA5}));
      tick();
      checkOutput("rd_t5_done", 32'(rsp_valid), 32'd0);
      checkOutput("wrrd_run0", runAt(0), 32'd1);
      checkOutput("wrrd_run1", runAt(1), 32'd1);
      clearLogs();

      $display("[TB] FIFO fill under response backpressure");
      rsp_ready = 1'b0;
      n = 0;
      firstLow = -1;
      for (int i = 0; i < 80 && n < 6; i++) begin
         if (i == 10) rsp_ready = 1'b1;
         cmd_we = 1'b1;
         cmd_adr = 8'(32'h20 + n);
         cmd_dat = 8'(32'h60 + n);
         cmd_valid = 1'b1;
         acc = cmd_ready;
         if (!cmd_ready && firstLow < 0) firstLow = i;
         tick();
         if (acc) n++;
      end
      cmd_valid = 1'b0;
      checkOutput("fill_first_stall", 32'(firstLow), 32'd5);
      checkOutput("fill_accepted", 32'(n), 32'd6);
      waitResponses(6);
      for (int k = 0; k < 6; k++) begin
         checkOutput("fill_order", adrAt(k), 32'h20 + 32'(k));
         checkOutput("fill_rsp", rspAt(k), 32'({1'b1, 1'b0, 8'h00}));
      end
      checkOutput("fill_no_dup", 32'(ackAdrQ.size()), 32'd6);
      repeat (2) tick();
      clearLogs();

      $display("[TB] ack timeout then normal command");
      ackMode = 1;
      applyStimulus(1'b0, 8'h10, 8'h00);
      applyStimulus(1'b1, 8'h11, 8'h77);
      waitResponses(2);
      checkOutput("to_rsp0", rspAt(0), 32'({1'b0, 1'b1, 8'h00}));
      checkOutput("to_rsp1", rspAt(1), 32'({1'b1, 1'b0, 8'h00}));
      checkOutput("to_run0", runAt(0), 32'd15);
      checkOutput("to_run1", runAt(1), 32'd1);
      checkOutput("to_acked", adrAt(0), 32'h11);
      repeat (2) tick();
      clearLogs();

      $display("[TB] ack on the final strobe cycle");
      ackMode = 2;
      applyStimulus(1'b0, 8'h30, 8'h00);
      waitResponses(1);
      checkOutput("late_rsp", rspAt(0), 32'({1'b0, 1'b0, 8'h0C}));
      checkOutput("late_run", runAt(0), 32'd15);
      repeat (2) tick();
      clearLogs();

      $display("[TB] response backpressure");
      ackMode = 0;
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 8'h05, 8'h00);
      applyStimulus(1'b1, 8'h41, 8'h11);
      for (int i = 0; i < 20 && !rsp_valid; i++) tick();
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_hold", 32'({rsp_valid, rsp_err, stb_o, rsp_dat}), 32'({1'b1, 1'b0, 1'b0, 8'hA5}));
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      checkOutput("bp_release", 32'(rsp_valid), 32'd0);
      waitResponses(2);
      checkOutput("bp_rsp0", rspAt(0), 32'({1'b0, 1'b0, 8'hA5}));
      checkOutput("bp_rsp1", rspAt(1), 32'({1'b1, 1'b0, 8'h00}));
      checkOutput("bp_second_adr", adrAt(1), 32'h41);
      repeat (2) tick();
      clearLogs();

      $display("[TB] reset during strobe");
      ackMode = 1;
      applyStimulus(1'b0, 8'h10, 8'h00);
      applyStimulus(1'b1, 8'h50, 8'h01);
      applyStimulus(1'b1, 8'h51, 8'h02);
      applyStimulus(1'b1, 8'h52, 8'h03);
      tick();
      checkOutput("mid_stb", 32'(stb_o), 32'd1);
      reset = 1'b1;
      tick();
      checkOutput("mid_rst_stb", 32'(stb_o), 32'd0);
      checkOutput("mid_rst_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;
      tick();
      clearLogs();
      ackMode = 0;
      repeat (30) tick();
      checkOutput("post_rst_rsp", 32'(rspQ.size()), 32'd0);
      checkOutput("post_rst_stb", 32'(runQ.size()), 32'd0);
      applyStimulus(1'b1, 8'h60, 8'h5A);
      checkOutput("new_t1", 32'(stb_o), 32'd0);
      tick();
      checkOutput("new_t2_bus", 32'({stb_o, we_o, adr_wr_o, dat_o}), 32'({1'b1, 1'b1, 8'h60, 8'h5A}));
      tick();
      checkOutput("new_t3_rsp", 32'({rsp_valid, rsp_we, rsp_err, rsp_dat}), 32'({1'b1, 1'b1, 1'b0, 8'h00}));
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
